tlu_trigger_emulator: RTL and testbench
=======================================

TLU_TRIGGER_EMULATOR -- requirements
Module: tlu_trigger_emulator

Interface
REQ-001 SHALL have parameter TRIGGER_BITS, default 15: width of the trigger number sent in the handshake.
REQ-002 SHALL have parameter TIMEOUT, default 65535: BUS_CLK cycles allowed per handshake phase before abort.
REQ-003 SHALL have port BUS_CLK, input, 1: the only clock.
REQ-004 SHALL have port BUS_RST, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port ENABLE, input, 1: level; trigger generation runs while high.
REQ-006 SHALL have port PERIOD, input, 32: BUS_CLK cycles between consecutive trigger assertions.
REQ-007 SHALL have port NUM_TRIGGERS, input, 32: triggers per run; 0 = unlimited.
REQ-008 SHALL have port TLU_BUSY, input, 1: DUT busy; asynchronous.
REQ-009 SHALL have port TLU_CLOCK, input, 1: DUT trigger clock; asynchronous.
REQ-010 SHALL have port TLU_TRIGGER, output, 1: trigger pulse, then serial trigger-number data.
REQ-011 SHALL have port TLU_RESET, output, 1: constant 0.
REQ-012 SHALL have port TRIGGER_NUMBER, output, TRIGGER_BITS: number of the next trigger to send.
REQ-013 SHALL have port TRIGGER_CNT, output, 32: triggers completed in the current run.
REQ-014 SHALL have port DONE, output, 1: run finished.
REQ-015 SHALL have port TIMEOUT_ERR, output, 1: sticky handshake-timeout flag.

Function
REQ-016 SHALL synchronise TLU_BUSY and TLU_CLOCK through 2 flops each; a TLU_CLOCK rising edge is detected with a third flop (edge visible 3 cycles after the pin change).
REQ-017 SHALL implement states IDLE, WAIT_PERIOD, TRIG, WAIT_CLK_SHIFT, WAIT_BUSY_LOW.
REQ-018 IDLE: on the rising edge of ENABLE, SHALL clear TRIGGER_CNT, DONE and TIMEOUT_ERR, load the period counter, and go to WAIT_PERIOD.
REQ-019 WAIT_PERIOD: SHALL count down from max(PERIOD,1); at 0, SHALL go to TRIG and reload the period counter, which keeps running in all later states.
REQ-020 TRIG: SHALL drive TLU_TRIGGER=1 (registered); on synchronised BUSY=1, SHALL load the shift register with TRIGGER_NUMBER and go to WAIT_CLK_SHIFT.
REQ-021 WAIT_CLK_SHIFT: TLU_TRIGGER SHALL equal shift register bit 0 (LSB first); each detected TLU_CLOCK rising edge SHALL shift right by one.
REQ-022 WAIT_CLK_SHIFT exit: after TRIGGER_BITS edges, SHALL drive TLU_TRIGGER=0 and go to WAIT_BUSY_LOW; any further TLU_CLOCK edges SHALL be ignored.
REQ-023 WAIT_BUSY_LOW: on synchronised BUSY=0, TRIGGER_NUMBER SHALL increment, wrapping modulo 2^TRIGGER_BITS.
REQ-024 WAIT_BUSY_LOW: on synchronised BUSY=0, TRIGGER_CNT SHALL increment, saturating at 2^32-1.
REQ-025 On leaving WAIT_BUSY_LOW, if NUM_TRIGGERS≠0 and TRIGGER_CNT reaches NUM_TRIGGERS, SHALL set DONE and go to IDLE.
REQ-026 Otherwise SHALL go to WAIT_PERIOD, or directly to TRIG if the period counter already reached 0; no trigger is queued or doubled.
REQ-027 If ENABLE falls, the current handshake SHALL complete; the block SHALL then go to IDLE without setting DONE, and no new trigger SHALL start.
REQ-028 In IDLE and WAIT_PERIOD, ENABLE=0 SHALL return to IDLE immediately.
REQ-029 Each of TRIG, WAIT_CLK_SHIFT and WAIT_BUSY_LOW SHALL have a TIMEOUT-cycle watchdog; on expiry, SHALL set TIMEOUT_ERR, drive TLU_TRIGGER=0 and go to IDLE with TRIGGER_NUMBER and TRIGGER_CNT unchanged.
REQ-030 BUSY already high on entry to TRIG SHALL be accepted on the first cycle; a BUSY drop during WAIT_CLK_SHIFT SHALL be ignored until WAIT_BUSY_LOW.
REQ-031 PERIOD and NUM_TRIGGERS SHALL be sampled at each use; changes mid-run take effect at the next reload or compare.

Reset
REQ-032 BUS_RST SHALL force IDLE and clear TLU_TRIGGER, TLU_RESET, TRIGGER_NUMBER, TRIGGER_CNT, DONE, TIMEOUT_ERR, the counters and all synchroniser flops.
REQ-033 BUS_RST mid-handshake SHALL drop TLU_TRIGGER to 0 asynchronously.
REQ-034 After BUS_RST, a high ENABLE SHALL NOT start a run until it is seen low and then high.

Structure
REQ-035 A shared package SHALL hold the state enumeration and the TRIGGER_BITS/TIMEOUT defaults.
REQ-036 The block SHALL use one sub-module, tlu_sync_edge (2-flop synchroniser plus rising-edge detect), instantiated for TLU_BUSY and TLU_CLOCK.

Verification
REQ-037 PERIOD=100, NUM_TRIGGERS=3, DUT model answers BUSY within 5 cycles and gives 15 clocks -> 3 triggers; number bits 0,1,2 appear LSB-first; TRIGGER_CNT=3; DONE=1; TRIGGER_NUMBER=3.
REQ-038 TRIGGER_NUMBER preset to 0x7FFF (TRIGGER_BITS=15), one trigger -> serial data 15 ones; afterwards TRIGGER_NUMBER=0.
REQ-039 TLU_BUSY never asserted, TIMEOUT=50 -> TLU_TRIGGER falls 50 cycles after rising; TIMEOUT_ERR=1; state IDLE; TRIGGER_CNT=0.
REQ-040 ENABLE dropped during the 7th TLU_CLOCK of the shift -> all 15 bits sent; BUSY low accepted; TRIGGER_CNT=1; IDLE with DONE=0.
REQ-041 PERIOD=10 with a 40-cycle handshake -> next TLU_TRIGGER rises 1 cycle after synchronised BUSY=0; no extra trigger.
REQ-042 BUS_RST asserted while TLU_TRIGGER carries a data bit of 1 -> TLU_TRIGGER=0 immediately; all outputs 0; ENABLE held high does not restart the run.

Source files
------------

// File: rtl/tlu_trigger_emulator_pkg.sv
// Shared types and defaults for the TLU trigger emulator.
// State encoding plus parameter defaults used by the top and the bench.
package tlu_trigger_emulator_pkg;

   localparam int TRIGGER_BITS_DEF = 15;
   localparam int TIMEOUT_DEF      = 65535;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_PERIOD,
      ST_TRIG,
      ST_WAIT_CLK_SHIFT,
      ST_WAIT_BUSY_LOW
   } state_e;

   // A zero period would never expire, so it behaves as one cycle.
   function automatic logic [31:0] period_load(input logic [31:0] p);
      return (p == 32'd0) ? 32'd1 : p;
   endfunction

endpackage

// File: rtl/tlu_trigger_emulator_if.sv
// TLU cable bundle: emulator (master) drives trigger/reset,
// the device under test (slave) answers with busy and clock.
interface tlu_trigger_emulator_if;
   logic busy;
   logic clock;
   logic trigger;
   logic reset;

   modport master (
      input  busy,
      input  clock,
      output trigger,
      output reset
   );

   modport slave (
      output busy,
      output clock,
      input  trigger,
      input  reset
   );
endinterface

// File: rtl/tlu_trigger_emulator_sync.sv
// Two-flop synchroniser with a third flop for rising-edge detect.
// Async active-high reset clears every stage.
module tlu_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o
);

   logic ff1_q, ff2_q, ff3_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
         ff3_q <= 1'b0;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
         ff3_q <= ff2_q;
      end
   end

   assign sync_o = ff2_q;
   assign rise_o = ff2_q & ~ff3_q;

endmodule

// File: rtl/tlu_trigger_emulator.sv
// TLU trigger emulator: periodic trigger, then LSB-first serial
// trigger number clocked out by the device's TLU_CLOCK.
module tlu_trigger_emulator
   import tlu_trigger_emulator_pkg::*;
#(
   parameter int TRIGGER_BITS = TRIGGER_BITS_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF
) (
   input  logic                    BUS_CLK,
   input  logic                    BUS_RST,
   input  logic                    ENABLE,
   input  logic [31:0]             PERIOD,
   input  logic [31:0]             NUM_TRIGGERS,
   input  logic                    TLU_BUSY,
   input  logic                    TLU_CLOCK,
   output logic                    TLU_TRIGGER,
   output logic                    TLU_RESET,
   output logic [TRIGGER_BITS-1:0] TRIGGER_NUMBER,
   output logic [31:0]             TRIGGER_CNT,
   output logic                    DONE,
   output logic                    TIMEOUT_ERR
);

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(TRIGGER_BITS + 1);

   tlu_trigger_emulator_if tlu ();

   logic busy_s, busy_rise;
   logic clk_lvl, clk_rise;
   logic unused_sync;

   assign tlu.busy  = TLU_BUSY;
   assign tlu.clock = TLU_CLOCK;

   tlu_sync_edge u_busy (
      .clk_i  (BUS_CLK),
      .rst_i  (BUS_RST),
      .d_i    (tlu.busy),
      .sync_o (busy_s),
      .rise_o (busy_rise)
   );

   tlu_sync_edge u_clk (
      .clk_i  (BUS_CLK),
      .rst_i  (BUS_RST),
      .d_i    (tlu.clock),
      .sync_o (clk_lvl),
      .rise_o (clk_rise)
   );

   state_e                  state_q, state_d;
   logic                    trig_q, trig_d;
   logic [TRIGGER_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]           bitcnt_q, bitcnt_d;
   logic [31:0]             pcnt_q, pcnt_d;
   logic [WW-1:0]           wdog_q, wdog_d;
   logic [TRIGGER_BITS-1:0] tnum_q, tnum_d;
   logic [31:0]             cnt_q, cnt_d;
   logic                    done_q, done_d;
   logic                    tmo_q, tmo_d;
   logic                    stop_q, stop_d;
   logic                    en_q;

   logic [31:0]             pload;
   logic [31:0]             cnt_inc;
   logic [TRIGGER_BITS-1:0] shift_nxt;
   logic                    wd_exp;
   logic                    last_bit;

   assign pload     = period_load(PERIOD);
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
   assign shift_nxt = shift_q >> 1;
   assign wd_exp    = (wdog_q == WW'(TIMEOUT - 1));
   assign last_bit  = (bitcnt_q + BW'(1)) == BW'(TRIGGER_BITS);

   assign unused_sync = ^{busy_rise, clk_lvl, shift_q[0]};

   // en_q resets high so a level-high ENABLE cannot start a run.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state_q  <= ST_IDLE;
         trig_q   <= 1'b0;
         shift_q  <= '0;
         bitcnt_q <= '0;
         pcnt_q   <= '0;
         wdog_q   <= '0;
         tnum_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         tmo_q    <= 1'b0;
         stop_q   <= 1'b0;
         en_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         trig_q   <= trig_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         pcnt_q   <= pcnt_d;
         wdog_q   <= wdog_d;
         tnum_q   <= tnum_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         tmo_q    <= tmo_d;
         stop_q   <= stop_d;
         en_q     <= ENABLE;
      end
   end

   always_comb begin
      state_d  = state_q;
      trig_d   = trig_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      pcnt_d   = (pcnt_q != 32'd0) ? pcnt_q - 32'd1 : pcnt_q;
      wdog_d   = wdog_q + WW'(1);
      tnum_d   = tnum_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      tmo_d    = tmo_q;
      stop_d   = stop_q;

      unique case (state_q)
         ST_IDLE: begin
            pcnt_d = pcnt_q;
            wdog_d = '0;
            if (ENABLE && !en_q) begin
               cnt_d   = '0;
               done_d  = 1'b0;
               tmo_d   = 1'b0;
               stop_d  = 1'b0;
               pcnt_d  = pload;
               state_d = ST_WAIT_PERIOD;
            end
         end
         ST_WAIT_PERIOD: begin
            wdog_d = '0;
            if (!ENABLE) begin
               state_d = ST_IDLE;
            end else if (pcnt_q == 32'd0) begin
               state_d = ST_TRIG;
               trig_d  = 1'b1;
               pcnt_d  = pload;
            end
         end
         ST_TRIG: begin
            if (!ENABLE) stop_d = 1'b1;
            if (busy_s) begin
               state_d  = ST_WAIT_CLK_SHIFT;
               shift_d  = tnum_q;
               bitcnt_d = '0;
               trig_d   = tnum_q[0];
               wdog_d   = '0;
            end else if (wd_exp) begin
               state_d = ST_IDLE;
               trig_d  = 1'b0;
               tmo_d   = 1'b1;
               wdog_d  = '0;
            end
         end
         ST_WAIT_CLK_SHIFT: begin
            if (!ENABLE) stop_d = 1'b1;
            if (clk_rise) begin
               shift_d  = shift_nxt;
               bitcnt_d = bitcnt_q + BW'(1);
               trig_d   = shift_nxt[0];
               if (last_bit) begin
                  state_d = ST_WAIT_BUSY_LOW;
                  trig_d  = 1'b0;
                  wdog_d  = '0;
               end
            end else if (wd_exp) begin
               state_d = ST_IDLE;
               trig_d  = 1'b0;
               tmo_d   = 1'b1;
               wdog_d  = '0;
            end
         end
         ST_WAIT_BUSY_LOW: begin
            if (!ENABLE) stop_d = 1'b1;
            if (!busy_s) begin
               tnum_d = tnum_q + TRIGGER_BITS'(1);
               cnt_d  = cnt_inc;
               wdog_d = '0;
               if (NUM_TRIGGERS != 32'd0 && cnt_inc >= NUM_TRIGGERS) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (stop_q || !ENABLE) begin
                  state_d = ST_IDLE;
               end else if (pcnt_q == 32'd0) begin
                  // Period already elapsed during the handshake.
                  state_d = ST_TRIG;
                  trig_d  = 1'b1;
                  pcnt_d  = pload;
               end else begin
                  state_d = ST_WAIT_PERIOD;
               end
            end else if (wd_exp) begin
               state_d = ST_IDLE;
               trig_d  = 1'b0;
               tmo_d   = 1'b1;
               wdog_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tlu.trigger    = trig_q;
   assign tlu.reset      = 1'b0;
   assign TLU_TRIGGER    = tlu.trigger;
   assign TLU_RESET      = tlu.reset;
   assign TRIGGER_NUMBER = tnum_q;
   assign TRIGGER_CNT    = cnt_q;
   assign DONE           = done_q;
   assign TIMEOUT_ERR    = tmo_q;

endmodule

// File: tb/tb_tlu_trigger_emulator.sv
// Bench for tlu_trigger_emulator: table of runs plus directed
// sequences for wrap, period overlap, timeout, ENABLE drop and reset.
module tb_tlu_trigger_emulator;
   import tlu_trigger_emulator_pkg::*;

   localparam int TB = 15;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [31:0]   period;
   logic [31:0]   num;
   logic [TB-1:0] tnum;
   logic [31:0]   tcnt;
   logic          done;
   logic          terr;

   tlu_trigger_emulator_if tif ();

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [TB-1:0] exp_tn;

   always #5 clk = ~clk;

   tlu_trigger_emulator #(
      .TRIGGER_BITS (TB),
      .TIMEOUT      (TO)
   ) dut (
      .BUS_CLK        (clk),
      .BUS_RST        (rst),
      .ENABLE         (enable),
      .PERIOD         (period),
      .NUM_TRIGGERS   (num),
      .TLU_BUSY       (tif.busy),
      .TLU_CLOCK      (tif.clock),
      .TLU_TRIGGER    (tif.trigger),
      .TLU_RESET      (tif.reset),
      .TRIGGER_NUMBER (tnum),
      .TRIGGER_CNT    (tcnt),
      .DONE           (done),
      .TIMEOUT_ERR    (terr)
   );

   typedef struct {
      logic [31:0]   period;
      logic [31:0]   num;
      int            bdel;
      logic [31:0]   exp_cnt;
      logic          exp_done;
      logic [TB-1:0] exp_tn;
   } vec_t;

   vec_t vecs [3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_run(input logic [31:0] p, input logic [31:0] n);
      enable = 1'b0;
      period = p;
      num    = n;
      tick();
      enable = 1'b1;
      tick();
   endtask

   task automatic wait_trig(output bit ok);
      int n = 0;
      while (!tif.trigger && n < 400) begin
         tick();
         n++;
      end
      ok = tif.trigger;
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL trigger start: got 0 expected 1 within 400 cycles");
      end
   endtask

   // Device model: answer busy, clock out TB bits, drop busy.
   task automatic handshake(input int bdel, input int drop_at,
                            output logic [TB-1:0] data, output int lat);
      bit ok;
      data = '0;
      lat  = -1;
      wait_trig(ok);
      if (!ok) return;
      repeat (bdel) tick();
      tif.busy = 1'b1;
      repeat (4) tick();
      for (int i = 0; i < TB; i++) begin
         data[i] = tif.trigger;
         if (i == drop_at) enable = 1'b0;
         tif.clock = 1'b1;
         tick();
         tif.clock = 1'b0;
         tick();
         tick();
      end
      chk("trigger low after bits", 32'(tif.trigger), 32'd0);
      repeat (3) tick();
      tif.busy = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (tif.trigger && lat < 0) lat = k;
      end
   endtask

   initial begin
      logic [TB-1:0] d;
      int            lat;
      int            hi;
      bit            ok;

      rst       = 1'b1;
      enable    = 1'b1;
      period    = '0;
      num       = '0;
      tif.busy  = 1'b0;
      tif.clock = 1'b0;
      tick();
      tick();
      chk("rst trigger", 32'(tif.trigger), 32'd0);
      chk("rst tlu_reset", 32'(tif.reset), 32'd0);
      chk("rst number", 32'(tnum), 32'd0);
      chk("rst cnt", tcnt, 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst timeout", 32'(terr), 32'd0);
      rst = 1'b0;
      hi  = 0;
      repeat (20) begin
         tick();
         if (tif.trigger) hi++;
      end
      chk("no start after rst", hi, 0);

      vecs[0] = '{period: 100, num: 3, bdel: 2, exp_cnt: 3,
                  exp_done: 1'b1, exp_tn: 15'd3};
      vecs[1] = '{period: 0, num: 2, bdel: 5, exp_cnt: 2,
                  exp_done: 1'b1, exp_tn: 15'd5};
      vecs[2] = '{period: 20, num: 1, bdel: 0, exp_cnt: 1,
                  exp_done: 1'b1, exp_tn: 15'd6};
      exp_tn = '0;
      for (int v = 0; v < 3; v++) begin
         start_run(vecs[v].period, vecs[v].num);
         for (int t = 0; t < int'(vecs[v].num); t++) begin
            handshake(vecs[v].bdel, -1, d, lat);
            chk($sformatf("run%0d data%0d", v, t), 32'(d), 32'(exp_tn));
            exp_tn++;
         end
         repeat (5) tick();
         chk($sformatf("run%0d cnt", v), tcnt, vecs[v].exp_cnt);
         chk($sformatf("run%0d done", v), 32'(done), 32'(vecs[v].exp_done));
         chk($sformatf("run%0d number", v), 32'(tnum), 32'(vecs[v].exp_tn));
      end

      // Wrap from all-ones to zero.
      force dut.tnum_q = 15'h7FFF;
      tick();
      tick();
      release dut.tnum_q;
      tick();
      chk("preset number", 32'(tnum), 32'h7FFF);
      start_run(5, 1);
      handshake(2, -1, d, lat);
      chk("wrap data", 32'(d), 32'h7FFF);
      repeat (5) tick();
      chk("wrap number", 32'(tnum), 32'd0);
      chk("wrap done", 32'(done), 32'd1);

      // Handshake longer than the period.
      start_run(10, 2);
      handshake(1, -1, d, lat);
      chk("overlap data0", 32'(d), 32'd0);
      chk("overlap latency", lat, 3);
      handshake(1, -1, d, lat);
      chk("overlap data1", 32'(d), 32'd1);
      repeat (5) tick();
      chk("overlap cnt", tcnt, 32'd2);
      chk("overlap done", 32'(done), 32'd1);
      hi = 0;
      repeat (40) begin
         tick();
         if (tif.trigger) hi++;
      end
      chk("overlap no extra", hi, 0);

      // Busy never answered.
      start_run(5, 1);
      wait_trig(ok);
      hi = 0;
      while (tif.trigger && hi < 200) begin
         tick();
         hi++;
      end
      chk("timeout high cycles", hi, TO);
      chk("timeout flag", 32'(terr), 32'd1);
      chk("timeout cnt", tcnt, 32'd0);
      chk("timeout state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("timeout number", 32'(tnum), 32'd2);
      chk("timeout done", 32'(done), 32'd0);

      // ENABLE falls during the 7th clock of the shift.
      start_run(10, 0);
      handshake(2, 6, d, lat);
      chk("drop data", 32'(d), 32'd2);
      chk("drop no retrigger", lat, -1);
      repeat (5) tick();
      chk("drop cnt", tcnt, 32'd1);
      chk("drop done", 32'(done), 32'd0);
      chk("drop state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("drop number", 32'(tnum), 32'd3);

      // Reset while the data line carries a 1 (number 3, bit 0).
      start_run(5, 0);
      wait_trig(ok);
      repeat (2) tick();
      tif.busy = 1'b1;
      repeat (4) tick();
      chk("mid bit is one", 32'(tif.trigger), 32'd1);
      rst = 1'b1;
      #1;
      chk("async trigger drop", 32'(tif.trigger), 32'd0);
      chk("rst2 number", 32'(tnum), 32'd0);
      chk("rst2 cnt", tcnt, 32'd0);
      chk("rst2 flags", 32'({done, terr, tif.reset}), 32'd0);
      tif.busy = 1'b0;
      tick();
      rst = 1'b0;
      hi  = 0;
      repeat (30) begin
         tick();
         if (tif.trigger) hi++;
      end
      chk("rst2 no restart", hi, 0);
      chk("rst2 state", 32'(dut.state_q), 32'(ST_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
